spi_master_ctrl: RTL and testbench

Clock-domain SPI master that drives the SCK/CSEL/MOSI lines towards the existing SPI slave port and captures its MISO reply. One transfer carries 1–8 bytes, MSB first. SCK idles low. MOSI changes on SCK rising edges and is sampled on falling edges. MISO is launched by the slave on rising edges and sampled here on falling edges. The block sits between the command sequencer and the board-level SPI pins; it is used for bench loopback and board-to-board links.

---
 rtl/spi_master_ctrl_pkg.sv | 39 +++
 rtl/spi_master_ctrl_if.sv | 31 +++
 rtl/spi_master_ctrl_sck_tick.sv | 40 ++++
 rtl/spi_master_ctrl.sv | 166 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_ctrl_pkg.sv
// spi_pkg: shared definitions for the SPI master controller.
//   spi_state_e  - controller FSM states
//   spi_msg_e    - message types; the sequencer maps these to byte_count
//   MAX_BYTES    - largest frame length in bytes
//   frame_bits() - byte_count -> frame length in bits (0 and >8 mean 8 bytes)
package spi_pkg;

    localparam int unsigned MAX_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } spi_state_e;

    typedef enum logic [2:0] {
        NO_BY,
        ONE_BY,
        STD_TWO_BY,
        THREE_BY,
        SIX_BY,
        LONG
    } spi_msg_e;

    // Frame length in bits (8..64) as a 7-bit value.
    function automatic logic [6:0] frame_bits(input logic [3:0] byte_count);
        logic [3:0] n;
        if (byte_count == 4'd0 || byte_count > 4'(MAX_BYTES)) begin
            n = 4'(MAX_BYTES);
        end else begin
            n = byte_count;
        end
        return {n, 3'b000};
    endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: command-side handshake plus SPI pins of the master.
//   start, tx_data[63:0], byte_count[3:0] - transfer request from sequencer
//   busy, done, rx_data[63:0]              - status / reply to sequencer
//   SCK, CSEL, MOSI                        - pins driven by the master
//   MISO                                   - pin driven by the slave
// Modport master is the controller side; modport slave is the far side.
interface spi_master_ctrl_if;
    import spi_pkg::*;

    logic        start;
    logic [63:0] tx_data;
    logic [3:0]  byte_count;
    logic        busy;
    logic        done;
    logic [63:0] rx_data;
    logic        SCK;
    logic        CSEL;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  start, tx_data, byte_count, MISO,
        output busy, done, rx_data, SCK, CSEL, MOSI
    );

    modport slave (
        output start, tx_data, byte_count, MISO,
        input  busy, done, rx_data, SCK, CSEL, MOSI
    );

endinterface

// File: rtl/spi_master_ctrl_sck_tick.sv
// spi_sck_tick: half-period counter for SCK generation.
//   CLK, RST  - system clock, synchronous active-high reset
//   en_i      - count while high
//   clr_i     - force count to 0 (has priority over en_i)
//   tick_o    - high in the cycle the count sits at CLK_DIV-1 while enabled;
//               the counter wraps to 0 on that cycle
module spi_sck_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master, 1..8 byte frames, MSB first, SCK idle low.
// MOSI changes on SCK rise, MISO is sampled on SCK fall.
//   CLK, RST - system clock, synchronous active-high reset
//   bus      - spi_master_ctrl_if.master (handshake + SPI pins)
//   CLK_DIV  - SCK half-period in CLK cycles (4..255)
// Build option: define SPI_MASTER_LOOPBACK_EN to capture the internal MOSI
// instead of the MISO pin (rx_data then equals tx_data masked to 8N bits).
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    spi_master_ctrl_if.master     bus
);

    spi_state_e  state_q, state_d;
    logic [63:0] tx_q, tx_d;
    logic [63:0] rx_sh_q, rx_sh_d;
    logic [63:0] rx_q, rx_d;
    logic [5:0]  bit_q, bit_d;
    logic        sck_q, sck_d;
    logic        csel_q, csel_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    // Set for the single IDLE cycle after GAP so a start there is dropped.
    logic        cool_q, cool_d;

    logic        tick;
    logic        rx_bit;
    logic [6:0]  nbits;
    logic [5:0]  bit_first;

    spi_sck_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_tick (
        .CLK    (CLK),
        .RST    (RST),
        .en_i   (state_q != IDLE),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = bus.MISO;
    assign rx_bit      = mosi_q;
`else
    assign rx_bit      = bus.MISO;
`endif

    assign nbits     = frame_bits(bus.byte_count);
    assign bit_first = 6'(nbits - 7'd1);

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        csel_d  = csel_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cool_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !cool_q) begin
                    state_d = SETUP;
                    tx_d    = bus.tx_data;
                    rx_sh_d = '0;
                    bit_d   = bit_first;
                    mosi_d  = bus.tx_data[bit_first];
                    csel_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT_HI;
                    sck_d   = 1'b1;
                end
            end
            SHIFT_HI: begin
                // Falling edge: capture the bit the slave launched on the rise.
                if (tick) begin
                    state_d = SHIFT_LO;
                    sck_d   = 1'b0;
                    rx_sh_d = {rx_sh_q[62:0], rx_bit};
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    if (bit_q == 6'd0) begin
                        state_d = HOLD;
                    end else begin
                        // Rising edge of a later bit: advance to the next MOSI bit.
                        state_d = SHIFT_HI;
                        sck_d   = 1'b1;
                        bit_d   = bit_q - 6'd1;
                        mosi_d  = tx_q[bit_q - 6'd1];
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = GAP;
                    csel_d  = 1'b1;
                    mosi_d  = 1'b0;
                    rx_d    = rx_sh_q;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cool_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            csel_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cool_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            csel_q  <= csel_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cool_q  <= cool_d;
        end
    end

    assign bus.SCK     = sck_q;
    assign bus.CSEL    = csel_q;
    assign bus.MOSI    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl with CLK_DIV=4.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_ctrl_if ifc ();

    spi_master_ctrl #(
        .CLK_DIV (4)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (ifc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: launches reply bits MSB first on SCK rising edges.
    logic        miso_r      = 1'b0;
    logic [63:0] slv_reply   = '0;
    int          slv_nbits   = 8;
    logic        slv_force1  = 1'b0;
    int          slv_cnt     = 0;
    assign ifc.MISO = miso_r;

    always @(posedge ifc.SCK or posedge ifc.CSEL) begin
        if (ifc.CSEL === 1'b1) begin
            slv_cnt = 0;
        end else begin
            if (slv_force1) miso_r = 1'b1;
            else if (slv_cnt < slv_nbits) miso_r = slv_reply[slv_nbits - 1 - slv_cnt];
            slv_cnt++;
        end
    end

    // Pin monitors.
    int          sck_rises   = 0;
    int          done_pulses = 0;
    logic [63:0] mosi_sh     = '0;
    always @(posedge ifc.SCK) sck_rises++;
    always @(negedge ifc.SCK) mosi_sh = {mosi_sh[62:0], ifc.MOSI};
    always @(negedge clk) if (ifc.done === 1'b1) done_pulses++;

    function automatic int bits_of(input logic [3:0] bc);
        return (bc == 4'd0 || bc > 4'd8) ? 64 : 8 * int'(bc);
    endfunction

    function automatic logic [63:0] mask_of(input int nb);
        return (nb >= 64) ? '1 : ((64'd1 << nb) - 64'd1);
    endfunction

    function automatic logic [63:0] exp_rx(input logic [63:0] tx, input logic [63:0] reply, input int nb);
`ifdef SPI_MASTER_LOOPBACK_EN
        return tx & mask_of(nb);
`else
        return reply & mask_of(nb);
`endif
    endfunction

    // Runs one frame; returns in the cycle busy falls.
    task automatic run_frame(input string tag, input logic [63:0] tx, input logic [3:0] bc,
                             input logic [63:0] reply, input int exp_lat);
        int nb;
        int lat;
        int g;
        int r0;
        logic [63:0] m;
        nb = bits_of(bc);
        m  = mask_of(nb);
        slv_reply = reply;
        slv_nbits = nb;
        r0 = sck_rises;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.tx_data = tx;
        ifc.byte_count = bc;
        @(posedge clk);
        #1 ifc.start = 1'b0;
        lat = 1;
        @(negedge clk);
        check({tag, "_csel_fall"}, 64'(ifc.CSEL), 64'd0);
        check({tag, "_mosi_first"}, 64'(ifc.MOSI), 64'(tx[nb - 1]));
        check({tag, "_busy"}, 64'(ifc.busy), 64'd1);
        while (ifc.done !== 1'b1 && lat < 3000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_done_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_rx_data"}, ifc.rx_data, exp_rx(tx, reply, nb));
        check({tag, "_sck_rises"}, 64'(sck_rises - r0), 64'(nb));
        check({tag, "_mosi_bits"}, mosi_sh & m, tx & m);
        g = 0;
        while (ifc.busy === 1'b1 && g < 100) begin
            @(posedge clk);
            g++;
            @(negedge clk);
        end
        check({tag, "_gap"}, 64'(g), 64'd4);
    endtask

    initial begin
        int d0;
        int n;
        int r0;
        ifc.start = 1'b0;
        ifc.tx_data = '0;
        ifc.byte_count = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_sck", 64'(ifc.SCK), 64'd0);
        check("rst_csel", 64'(ifc.CSEL), 64'd1);
        check("rst_mosi", 64'(ifc.MOSI), 64'd0);
        check("rst_busy", 64'(ifc.busy), 64'd0);
        check("rst_done", 64'(ifc.done), 64'd0);
        check("rst_rx", ifc.rx_data, 64'd0);

        // 2 bytes: done at 1 + 4*(2*16+2) = 137.
        run_frame("n2", 64'hA5C3, 4'd2, 64'h1234, 137);
        // 1 byte: done at 1 + 4*18 = 73; MOSI high only on the first bit.
        run_frame("n1", 64'h80, 4'd1, 64'h5A, 73);
        check("n1_rx_upper_zero", ifc.rx_data >> 8, 64'd0);
        // byte_count 0 -> 8 bytes: done at 1 + 4*130 = 521.
        run_frame("n8", 64'h0123456789ABCDEF, 4'd0, 64'h0123456789ABCDEF, 521);
        // byte_count 12 clamps to 8 bytes.
        run_frame("clamp", 64'hFEDCBA9876543210, 4'd12, 64'h0F1E2D3C4B5A6978, 521);

        // start mid-frame and in the busy-fall cycle are both dropped.
        slv_reply = 64'h33;
        slv_nbits = 8;
        d0 = done_pulses;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.tx_data = 64'h55;
        ifc.byte_count = 4'd1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (20) @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        n = 0;
        while (ifc.busy === 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ign_busy_fell", 64'(ifc.busy), 64'd0);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        check("ign_fall_cycle", 64'(ifc.busy), 64'd0);
        repeat (10) @(negedge clk);
        check("ign_still_idle", 64'(ifc.busy), 64'd0);
        @(posedge clk);
        #1 check("ign_one_done", 64'(done_pulses - d0), 64'd1);

        // start held high: frames every 4*(2*8+3)+2 = 78 cycles.
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.tx_data = 64'h3C;
        ifc.byte_count = 4'd1;
        n = 0;
        while (ifc.done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifc.done !== 1'b1 && n < 500);
        ifc.start = 1'b0;
        check("b2b_period", 64'(n), 64'd78);
        n = 0;
        while (ifc.busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);

        // Reset during bit 5 of a 2-byte frame.
        slv_reply = 64'h1234;
        slv_nbits = 16;
        r0 = sck_rises;
        ifc.start = 1'b1;
        ifc.tx_data = 64'hA5C3;
        ifc.byte_count = 4'd2;
        @(negedge clk);
        ifc.start = 1'b0;
        n = 0;
        while ((sck_rises - r0) < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reached_bit5", 64'(sck_rises - r0), 64'd5);
        @(posedge clk);
        @(posedge clk);
        d0 = done_pulses;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_csel", 64'(ifc.CSEL), 64'd1);
        check("rstmid_sck", 64'(ifc.SCK), 64'd0);
        check("rstmid_mosi", 64'(ifc.MOSI), 64'd0);
        check("rstmid_busy", 64'(ifc.busy), 64'd0);
        check("rstmid_rx", ifc.rx_data, 64'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        @(posedge clk);
        #1 check("rstmid_no_done", 64'(done_pulses - d0), 64'd0);
        check("rstmid_idle_csel", 64'(ifc.CSEL), 64'd1);

`ifdef SPI_MASTER_LOOPBACK_EN
        slv_force1 = 1'b1;
        run_frame("loop", 64'h3C, 4'd1, 64'hFF, 73);
        check("loop_rx", ifc.rx_data, 64'h3C);
        slv_force1 = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
